// File: rtl/input_buffer_nch_pkg.sv
// Shared definitions for the per-channel activation input buffer.
package input_buffer_nch_pkg;

    localparam int DAT_WIDTH_DEF = 8;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/input_buffer_nch_if.sv
// Write/read/status bundle between the activation loader and the input buffer.
interface input_buffer_nch_if
    import input_buffer_nch_pkg::*;
#(
    parameter int DAT_WIDTH     = DAT_WIDTH_DEF,
    parameter int NUM_CHANNEL   = 3,
    parameter int NUM_RDATA     = 3,
    parameter int FF_ADDR_WIDTH = 3
);
    logic                                        i_flush;
    logic [FF_ADDR_WIDTH:0]                      i_stride;
    logic [NUM_CHANNEL*DAT_WIDTH-1:0]            i_data;
    logic [NUM_CHANNEL-1:0]                      i_data_val;
    logic [NUM_CHANNEL-1:0]                      o_wr_ready;
    logic                                        i_data_req;
    logic                                        o_rd_ready;
    logic [NUM_CHANNEL*NUM_RDATA*DAT_WIDTH-1:0]  o_data;
    logic                                        o_data_val;
    logic [NUM_CHANNEL*(FF_ADDR_WIDTH+1)-1:0]    o_data_count;
    logic                                        o_overflow;
    logic                                        o_underflow;

    modport master (
        output i_flush, i_stride, i_data, i_data_val, i_data_req,
        input  o_wr_ready, o_rd_ready, o_data, o_data_val, o_data_count,
               o_overflow, o_underflow
    );

    modport slave (
        input  i_flush, i_stride, i_data, i_data_val, i_data_req,
        output o_wr_ready, o_rd_ready, o_data, o_data_val, o_data_count,
               o_overflow, o_underflow
    );

endinterface

// File: rtl/input_buffer_nch_fifo_p1on.sv
// One channel: 1-in / NUM_RDATA-out circular buffer with stride pop and flush.
module fifo_p1on
    import input_buffer_nch_pkg::*;
#(
    parameter int DAT_WIDTH     = DAT_WIDTH_DEF,
    parameter int NUM_RDATA     = 3,
    parameter int FF_DEPTH      = 8,
    parameter int FF_ADDR_WIDTH = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           wr_en,
    input  logic [DAT_WIDTH-1:0]           wr_data,
    input  logic                           pop,
    input  logic [FF_ADDR_WIDTH:0]         stride,
    output logic [NUM_RDATA*DAT_WIDTH-1:0] window,
    output logic [FF_ADDR_WIDTH:0]         count,
    output logic                           wr_ready
);
    localparam int CW = FF_ADDR_WIDTH + 1;
    localparam logic [CW-1:0] FULL = CW'(FF_DEPTH);

    logic [DAT_WIDTH-1:0]     mem [FF_DEPTH];
    logic [FF_ADDR_WIDTH-1:0] wr_ptr;
    logic [FF_ADDR_WIDTH-1:0] rd_ptr;
    logic                     wr_acc;

    assign wr_ready = (count != FULL);
    assign wr_acc   = wr_en && wr_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            // Power-of-two depth: pointer overflow is the wrap.
            if (pop) rd_ptr <= rd_ptr + stride[FF_ADDR_WIDTH-1:0];
            count <= count + CW'(wr_acc) - (pop ? stride : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !flush && !rst) mem[wr_ptr] <= wr_data;
    end

    always_comb begin
        window = '0;
        for (int k = 0; k < NUM_RDATA; k++) begin
            window[k*DAT_WIDTH +: DAT_WIDTH] = mem[rd_ptr + FF_ADDR_WIDTH'(k)];
        end
    end

endmodule

// File: rtl/input_buffer_nch.sv
// Multi-channel activation input buffer: aligned sliding-window reads over per-channel FIFOs.
module input_buffer_nch
    import input_buffer_nch_pkg::*;
#(
    parameter int DAT_WIDTH     = DAT_WIDTH_DEF,
    parameter int NUM_CHANNEL   = 3,
    parameter int NUM_RDATA     = 3,
    parameter int FF_DEPTH      = 8,
    parameter int FF_ADDR_WIDTH = clog2(FF_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input_buffer_nch_if.slave   bus
);
    localparam int CW = FF_ADDR_WIDTH + 1;
    localparam int WW = NUM_RDATA * DAT_WIDTH;
    localparam logic [CW-1:0] RD_NEED = CW'(NUM_RDATA);

    function automatic logic [CW-1:0] sat_stride(input logic [CW-1:0] stride);
        if (stride == '0 || stride > RD_NEED) return RD_NEED;
        return stride;
    endfunction

    logic [CW-1:0]             count [NUM_CHANNEL];
    logic [NUM_CHANNEL-1:0]    wr_ready;
    logic [NUM_CHANNEL*WW-1:0] window_all;
    logic [CW-1:0]             stride_eff;
    logic                      rd_ready;
    logic                      pop_p0;
    logic [NUM_CHANNEL*WW-1:0] data_p1;
    logic                      vld_p1;
    logic                      overflow;
    logic                      underflow;

    always_comb begin
        rd_ready = 1'b1;
        for (int c = 0; c < NUM_CHANNEL; c++) begin
            if (count[c] < RD_NEED) rd_ready = 1'b0;
        end
    end

    assign stride_eff = sat_stride(bus.i_stride);
    assign pop_p0     = bus.i_data_req && rd_ready && !bus.i_flush;

    for (genvar c = 0; c < NUM_CHANNEL; c++) begin : g_ch
        fifo_p1on #(
            .DAT_WIDTH     (DAT_WIDTH),
            .NUM_RDATA     (NUM_RDATA),
            .FF_DEPTH      (FF_DEPTH),
            .FF_ADDR_WIDTH (FF_ADDR_WIDTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .flush    (bus.i_flush),
            .wr_en    (bus.i_data_val[c]),
            .wr_data  (bus.i_data[c*DAT_WIDTH +: DAT_WIDTH]),
            .pop      (pop_p0),
            .stride   (stride_eff),
            .window   (window_all[c*WW +: WW]),
            .count    (count[c]),
            .wr_ready (wr_ready[c])
        );
        assign bus.o_data_count[c*CW +: CW] = count[c];
    end

    // Stage p0 -> p1: window capture and error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            data_p1   <= '0;
            vld_p1    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            vld_p1 <= pop_p0;
            if (pop_p0) data_p1 <= window_all;
            // A flush discards its cycle's traffic, so it cannot raise an error.
            if (!bus.i_flush) begin
                if (|(bus.i_data_val & ~wr_ready)) overflow <= 1'b1;
                if (bus.i_data_req && !rd_ready)   underflow <= 1'b1;
            end
        end
    end

    assign bus.o_wr_ready  = wr_ready;
    assign bus.o_rd_ready  = rd_ready;
    assign bus.o_data      = data_p1;
    assign bus.o_data_val  = vld_p1;
    assign bus.o_overflow  = overflow;
    assign bus.o_underflow = underflow;

endmodule

// File: tb/tb_input_buffer_nch.sv
// Bench for input_buffer_nch: queue-based reference model plus directed window checks.
module tb_input_buffer_nch;
    localparam int NC    = 3;
    localparam int NR    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    input_buffer_nch_if #(.DAT_WIDTH(DW), .NUM_CHANNEL(NC), .NUM_RDATA(NR), .FF_ADDR_WIDTH(3)) bus();

    input_buffer_nch #(
        .DAT_WIDTH(DW), .NUM_CHANNEL(NC), .NUM_RDATA(NR), .FF_DEPTH(DEPTH), .FF_ADDR_WIDTH(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: each channel is a plain queue of elements.
    logic [DW-1:0]         mq [NC][$];
    logic [NC*NR*DW-1:0]   m_data;
    logic                  m_val;
    logic                  m_ovf;
    logic                  m_unf;
    bit                    started = 0;

    always @(posedge clk) begin : model
        int  s;
        int  st;
        bit  rdy;
        bit  full [NC];
        if (rst) begin
            for (int c = 0; c < NC; c++) mq[c].delete();
            m_data = '0;
            m_val  = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else if (bus.i_flush) begin
            for (int c = 0; c < NC; c++) mq[c].delete();
            m_val = 1'b0;
        end else begin
            rdy = 1;
            for (int c = 0; c < NC; c++) begin
                full[c] = (mq[c].size() == DEPTH);
                if (mq[c].size() < NR) rdy = 0;
                if (bus.i_data_val[c] && full[c]) m_ovf = 1'b1;
            end
            st = int'(bus.i_stride);
            s  = (st == 0 || st > NR) ? NR : st;
            if (bus.i_data_req && !rdy) m_unf = 1'b1;
            m_val = bus.i_data_req && rdy;
            if (m_val) begin
                for (int c = 0; c < NC; c++) begin
                    for (int k = 0; k < NR; k++) m_data[(c*NR+k)*DW +: DW] = mq[c][k];
                    for (int j = 0; j < s; j++) void'(mq[c].pop_front());
                end
            end
            for (int c = 0; c < NC; c++) begin
                if (bus.i_data_val[c] && !full[c]) mq[c].push_back(bus.i_data[c*DW +: DW]);
            end
        end
        started = 1;
    end

    always @(negedge clk) begin : cmp
        logic [NC-1:0]    ewr;
        logic [NC*CW-1:0] ecnt;
        logic             erd;
        if (started) begin
            erd = 1'b1;
            for (int c = 0; c < NC; c++) begin
                ewr[c] = (mq[c].size() != DEPTH);
                ecnt[c*CW +: CW] = CW'(mq[c].size());
                if (mq[c].size() < NR) erd = 1'b0;
            end
            chk("m_wr_ready", 128'(bus.o_wr_ready), 128'(ewr));
            chk("m_rd_ready", 128'(bus.o_rd_ready), 128'(erd));
            chk("m_count", 128'(bus.o_data_count), 128'(ecnt));
            chk("m_data_val", 128'(bus.o_data_val), 128'(m_val));
            chk("m_data", 128'(bus.o_data), 128'(m_data));
            chk("m_overflow", 128'(bus.o_overflow), 128'(m_ovf));
            chk("m_underflow", 128'(bus.o_underflow), 128'(m_unf));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr3(input logic [2:0] m, input int a, input int b, input int c2);
        bus.i_data_val = m;
        bus.i_data     = {c2[7:0], b[7:0], a[7:0]};
        step();
        bus.i_data_val = '0;
    endtask

    task automatic req(input int st);
        bus.i_stride   = 4'(st);
        bus.i_data_req = 1'b1;
        step();
        bus.i_data_req = 1'b0;
    endtask

    function automatic logic [NC*NR*DW-1:0] win(input int base, input int first);
        logic [NC*NR*DW-1:0] r;
        r = '0;
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < NR; k++)
                r[(c*NR+k)*DW +: DW] = 8'(first + k + base*c);
        return r;
    endfunction

    initial begin
        bus.i_flush    = 1'b0;
        bus.i_stride   = 4'd3;
        bus.i_data     = '0;
        bus.i_data_val = '0;
        bus.i_data_req = 1'b0;
        rst = 1'b1;
        step();
        step();
        chk("t1_wr_ready", 128'(bus.o_wr_ready), 128'(3'b111));
        chk("t1_rd_ready", 128'(bus.o_rd_ready), 128'(1'b0));
        chk("t1_val", 128'(bus.o_data_val), 128'(1'b0));
        chk("t1_count", 128'(bus.o_data_count), 128'(12'h000));
        chk("t1_flags", 128'({bus.o_overflow, bus.o_underflow}), 128'(2'b00));
        rst = 1'b0;

        for (int i = 1; i <= 6; i++) wr3(3'b111, i, i + 10, i + 20);
        chk("t2_count6", 128'(bus.o_data_count), 128'(12'h666));
        req(3);
        chk("t2_val1", 128'(bus.o_data_val), 128'(1'b1));
        chk("t2_win1", 128'(bus.o_data), 128'(win(10, 1)));
        req(3);
        chk("t2_win2", 128'(bus.o_data), 128'(win(10, 4)));
        step();
        chk("t2_val_end", 128'(bus.o_data_val), 128'(1'b0));
        chk("t2_count_end", 128'(bus.o_data_count), 128'(12'h000));

        for (int i = 1; i <= 5; i++) wr3(3'b111, i, i, i);
        req(1);
        chk("t3_win1", 128'(bus.o_data), 128'(win(0, 1)));
        req(1);
        chk("t3_win2", 128'(bus.o_data), 128'(win(0, 2)));
        req(1);
        chk("t3_win3", 128'(bus.o_data), 128'(win(0, 3)));
        chk("t3_count", 128'(bus.o_data_count), 128'(12'h222));
        bus.i_flush = 1'b1;
        step();
        bus.i_flush = 1'b0;
        chk("t3_flush_count", 128'(bus.o_data_count), 128'(12'h000));

        for (int i = 1; i <= 8; i++) wr3(3'b111, i, i, i);
        chk("t4_full_ready", 128'(bus.o_wr_ready), 128'(3'b000));
        chk("t4_full_count", 128'(bus.o_data_count), 128'(12'h888));
        wr3(3'b111, 99, 99, 99);
        chk("t4_overflow", 128'(bus.o_overflow), 128'(1'b1));
        chk("t4_drop_count", 128'(bus.o_data_count), 128'(12'h888));
        req(3);
        chk("t4_win1", 128'(bus.o_data), 128'(win(0, 1)));
        for (int i = 9; i <= 11; i++) wr3(3'b111, i, i, i);
        req(3);
        chk("t4_win2", 128'(bus.o_data), 128'(win(0, 4)));
        req(3);
        chk("t4_win3", 128'(bus.o_data), 128'(win(0, 7)));
        wr3(3'b111, 12, 12, 12);
        req(0);
        chk("t4_win4_wrap", 128'(bus.o_data), 128'(win(0, 10)));

        bus.i_flush = 1'b1;
        step();
        bus.i_flush = 1'b0;
        for (int i = 1; i <= 5; i++) wr3((i <= 2) ? 3'b111 : 3'b101, i, i, i);
        req(3);
        chk("t5_val", 128'(bus.o_data_val), 128'(1'b0));
        chk("t5_underflow", 128'(bus.o_underflow), 128'(1'b1));
        chk("t5_count", 128'(bus.o_data_count), 128'(12'h525));
        chk("t5_data_kept", 128'(bus.o_data), 128'(win(0, 10)));

        bus.i_flush = 1'b1;
        step();
        bus.i_flush = 1'b0;
        for (int i = 1; i <= 3; i++) wr3(3'b111, i, i, i);
        bus.i_data_val = 3'b111;
        bus.i_data     = {8'd4, 8'd4, 8'd4};
        req(1);
        bus.i_data_val = '0;
        chk("t6_rw_val", 128'(bus.o_data_val), 128'(1'b1));
        chk("t6_rw_win", 128'(bus.o_data), 128'(win(0, 1)));
        chk("t6_rw_count", 128'(bus.o_data_count), 128'(12'h333));
        bus.i_flush    = 1'b1;
        bus.i_data_req = 1'b1;
        step();
        bus.i_flush    = 1'b0;
        bus.i_data_req = 1'b0;
        chk("t6_flush_count", 128'(bus.o_data_count), 128'(12'h000));
        chk("t6_flush_val", 128'(bus.o_data_val), 128'(1'b0));
        chk("t6_flags_kept", 128'({bus.o_overflow, bus.o_underflow}), 128'(2'b11));

        for (int i = 1; i <= 3; i++) wr3(3'b111, i, i, i);
        rst            = 1'b1;
        bus.i_data_req = 1'b1;
        step();
        rst            = 1'b0;
        bus.i_data_req = 1'b0;
        chk("t7_rst_val", 128'(bus.o_data_val), 128'(1'b0));
        chk("t7_rst_flags", 128'({bus.o_overflow, bus.o_underflow}), 128'(2'b00));
        chk("t7_rst_count", 128'(bus.o_data_count), 128'(12'h000));
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
